seg_scan_reader: RTL and testbench

- Monitors the pins of an active-low, multiplexed 7-segment display: per-digit select lines plus shared segment lines.
- Recovers the BCD value and decimal point shown on each digit.
- Sits beside the display driver as a self-check and readback path, so lock logic and test benches can confirm what the user actually sees.
- Includes glitch filtering, pattern validation, frame tracking and scan-loss detection.

---
 rtl/seg_scan_reader.sv | 154 +++++++++++++++
 tb/tb_seg_scan_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_reader.sv
// Readback monitor for an active-low multiplexed 7-segment display.
// Recovers per-digit BCD/dp with glitch filtering, frame tracking and scan-loss detection.
module seg_scan_reader #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_DIGITS-1:0]     dig_sel,
  input  logic [7:0]                seg_in,
  output logic [4*NUM_DIGITS-1:0]   bcd_out,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      bad_pattern,
  output logic                      frame_done,
  output logic                      scan_lost
);

  localparam int KW = NUM_DIGITS + 8;
  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [KW-1:0]         key_q;
  logic [SW-1:0]         stab_q;
  logic                  done_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [TW-1:0]         tmo_q;

  logic [KW-1:0]         key_in;
  logic                  key_chg;
  logic                  commit;
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0]            seg;
  logic                  sel_idle;
  logic                  sel_one;
  logic                  single;
  logic [IW-1:0]         idx;
  logic [NUM_DIGITS-1:0] mask_nxt;
  logic [3:0]            dec_val;
  logic                  dec_ok;
  logic                  dec_blank;

  assign key_in  = {dig_sel, seg_in};
  assign key_chg = key_in != key_q;
  assign commit  = !done_q && (stab_q == STAB_MAX);

  assign sel      = key_q[KW-1:8];
  assign seg      = key_q[7:0];
  assign sel_idle = &sel;
  assign sel_one  = $onehot(~sel);
  assign single   = commit && sel_one;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel[i]) idx = IW'(i);
    end
  end

  assign mask_nxt = mask_q | (NUM_DIGITS'(1) << idx);

  always_comb begin
    dec_val   = 4'hF;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    unique case (1'b1)
      (seg[6:0] == 7'h40): dec_val = 4'd0;
      (seg[6:0] == 7'h79): dec_val = 4'd1;
      (seg[6:0] == 7'h24): dec_val = 4'd2;
      (seg[6:0] == 7'h30): dec_val = 4'd3;
      (seg[6:0] == 7'h19): dec_val = 4'd4;
      (seg[6:0] == 7'h12): dec_val = 4'd5;
      (seg[6:0] == 7'h02): dec_val = 4'd6;
      (seg[6:0] == 7'h78): dec_val = 4'd7;
      (seg[6:0] == 7'h00): dec_val = 4'd8;
      (seg[6:0] == 7'h10): dec_val = 4'd9;
      (seg[6:0] == 7'h7F): begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Stability tracking: one commit per stable run of the sampled key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '1;
      stab_q <= '0;
      done_q <= 1'b0;
    end else begin
      key_q <= key_in;
      if (key_chg) begin
        stab_q <= '0;
        done_q <= 1'b0;
      end else begin
        if (stab_q != STAB_MAX) stab_q <= stab_q + SW'(1);
        if (commit) done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out     <= '1;
      dp_out      <= '0;
      digit_valid <= '0;
      bad_pattern <= 1'b0;
      frame_done  <= 1'b0;
      scan_lost   <= 1'b0;
      mask_q      <= '0;
      tmo_q       <= '0;
    end else begin
      bad_pattern <= 1'b0;
      frame_done  <= 1'b0;
      if (commit && !sel_idle && !sel_one) bad_pattern <= 1'b1;
      if (single) begin
        dp_out[idx] <= ~seg[7];
        if (dec_ok) begin
          bcd_out[{idx, 2'b00} +: 4] <= dec_val;
          digit_valid[idx]           <= 1'b1;
        end else if (dec_blank) begin
          bcd_out[{idx, 2'b00} +: 4] <= 4'hF;
          digit_valid[idx]           <= 1'b0;
        end else begin
          bad_pattern <= 1'b1;
        end
        if (&mask_nxt) begin
          frame_done <= 1'b1;
          mask_q     <= '0;
        end else begin
          mask_q <= mask_nxt;
        end
        tmo_q     <= '0;
        scan_lost <= 1'b0;
      end else if (tmo_q != TMO_MAX) begin
        tmo_q <= tmo_q + TW'(1);
        // Timeout fires once; the counter then parks at its limit.
        if (tmo_q == TMO_LAST) begin
          scan_lost   <= 1'b1;
          digit_valid <= '0;
          mask_q      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: vector table with scoreboard,
// plus timeout and mid-scan reset sequences.
module tb_seg_scan_reader;

  localparam int N = 4;
  localparam int S = 4;
  localparam int T = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  dig_sel = '1;
  logic [7:0]    seg_in = '1;
  logic [4*N-1:0] bcd_out;
  logic [N-1:0]  dp_out;
  logic [N-1:0]  digit_valid;
  logic          bad_pattern;
  logic          frame_done;
  logic          scan_lost;

  seg_scan_reader #(
    .NUM_DIGITS(N),
    .STABLE_CYCLES(S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dig_sel(dig_sel),
    .seg_in(seg_in),
    .bcd_out(bcd_out),
    .dp_out(dp_out),
    .digit_valid(digit_valid),
    .bad_pattern(bad_pattern),
    .frame_done(frame_done),
    .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  vld;
    logic        bad;
    logic        frm;
    logic        lost;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    int         hold;
    exp_t       e;
  } vec_t;

  int   n_pass = 0;
  int   n_chk = 0;
  vec_t tbl[13];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input exp_t e);
    chk({nm, "_bcd"}, 32'(bcd_out), 32'(e.bcd));
    chk({nm, "_dp"}, 32'(dp_out), 32'(e.dp));
    chk({nm, "_vld"}, 32'(digit_valid), 32'(e.vld));
    chk({nm, "_bad"}, 32'(bad_pattern), 32'(e.bad));
    chk({nm, "_frm"}, 32'(frame_done), 32'(e.frm));
    chk({nm, "_lost"}, 32'(scan_lost), 32'(e.lost));
  endtask

  function automatic vec_t mk(input logic [3:0] s, input logic [7:0] g,
                              input int h, input logic [15:0] b,
                              input logic [3:0] d, input logic [3:0] v,
                              input logic bad, input logic frm);
    vec_t r;
    r.sel = s;
    r.seg = g;
    r.hold = h;
    r.e = '{bcd: b, dp: d, vld: v, bad: bad, frm: frm, lost: 1'b0};
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic extra;
    exp_t e;
    extra = 1'b0;
    dig_sel = v.sel;
    seg_in = v.seg;
    if (v.hold > S) sb.push_back(v.e);
    for (int k = 1; k <= v.hold; k++) begin
      @(posedge clk);
      #1;
      if (k == S + 1) begin
        e = sb.pop_front();
        chk_out($sformatf("v%0d", id), e);
      end else begin
        extra |= bad_pattern | frame_done;
      end
    end
    chk($sformatf("v%0d_nopulse", id), 32'(extra), 32'd0);
  endtask

  exp_t rst_e;
  exp_t e2;
  int   first;

  initial begin
    rst_e = '{bcd: 16'hFFFF, dp: 4'h0, vld: 4'h0,
              bad: 1'b0, frm: 1'b0, lost: 1'b0};
    tbl[0]  = mk(4'hF, 8'hFF, 100, 16'hFFFF, 4'h0, 4'h0, 0, 0);
    tbl[1]  = mk(4'hE, 8'hB0, 10, 16'hFFF3, 4'h0, 4'h1, 0, 0);
    tbl[2]  = mk(4'hE, 8'hC0, 8, 16'hFFF0, 4'h0, 4'h1, 0, 0);
    tbl[3]  = mk(4'hD, 8'hF9, 8, 16'hFF10, 4'h0, 4'h3, 0, 0);
    tbl[4]  = mk(4'hB, 8'h24, 8, 16'hF210, 4'h4, 4'h7, 0, 0);
    tbl[5]  = mk(4'h7, 8'h90, 8, 16'h9210, 4'h4, 4'hF, 0, 1);
    tbl[6]  = mk(4'hD, 8'h88, 8, 16'h9210, 4'h4, 4'hF, 1, 0);
    tbl[7]  = mk(4'hC, 8'hC0, 8, 16'h9210, 4'h4, 4'hF, 1, 0);
    tbl[8]  = mk(4'hB, 8'h40, 3, 16'h9210, 4'h4, 4'hF, 0, 0);
    tbl[9]  = mk(4'hF, 8'hFF, 8, 16'h9210, 4'h4, 4'hF, 0, 0);
    tbl[10] = mk(4'hB, 8'hFF, 8, 16'h9F10, 4'h0, 4'hB, 0, 0);
    tbl[11] = mk(4'hE, 8'h19, 8, 16'h9F14, 4'h1, 4'hB, 0, 0);
    tbl[12] = mk(4'h7, 8'h92, 8, 16'h5F14, 4'h1, 4'hB, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", rst_e);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

    dig_sel = 4'hD;
    seg_in = 8'hF9;
    repeat (S + 1) @(posedge clk);
    #1;
    chk("pre_tmo_bcd", 32'(bcd_out), 32'h5F14);
    chk("pre_tmo_lost", 32'(scan_lost), 32'd0);
    dig_sel = 4'hF;
    seg_in = 8'hFF;
    first = 0;
    for (int n = 1; n <= 200 && first == 0; n++) begin
      @(posedge clk);
      #1;
      if (scan_lost) first = n;
    end
    chk("tmo_cycles", 32'(first), 32'(T));
    e2 = '{bcd: 16'h5F14, dp: 4'h1, vld: 4'h0,
           bad: 1'b0, frm: 1'b0, lost: 1'b1};
    chk_out("tmo", e2);

    dig_sel = 4'hB;
    seg_in = 8'hC0;
    repeat (S + 1) @(posedge clk);
    #1;
    e2 = '{bcd: 16'h5014, dp: 4'h1, vld: 4'h4,
           bad: 1'b0, frm: 1'b0, lost: 1'b0};
    chk_out("recover", e2);

    dig_sel = 4'hE;
    seg_in = 8'h79;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", rst_e);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
